// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard sequencer state and drain depth.
`default_nettype none

package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hzd_state_t;

  // Halt sits in ID when DRAIN starts; it must advance through EX, MEM and into WB.
  localparam int DRAIN_STAGES = 3;
  localparam int DRAIN_CNT_W  = 2;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};
  localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != C_MAX)) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, cache-miss freeze,
// taken-branch flush and halt drain, with saturating stall/flush counters.
`default_nettype none

module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_halt,
  input  regbits_t         ex_writeReg,
  input  logic             ex_regWEN,
  input  logic             ex_dmemREN,
  input  logic             mem_dmemREN,
  input  logic             mem_dmemWEN,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [DRAIN_CNT_W-1:0] C_DRAIN_LAST = DRAIN_CNT_W'(DRAIN_STAGES - 1);
  localparam logic [DRAIN_CNT_W-1:0] C_DRAIN_ONE  = DRAIN_CNT_W'(1);

  hzd_state_t             state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic memwait, lduse, adv;
  logic pc_en_w, ifid_en_w, idex_en_w, exmem_en_w, memwb_en_w;
  logic ifid_flush_w, idex_flush_w, halt_w;
  logic stall_inc, flush_inc;

  assign memwait = (mem_dmemREN | mem_dmemWEN) & ~dhit;
  assign lduse   = ex_dmemREN & ex_regWEN & (ex_writeReg != '0) &
                   ((ex_writeReg == id_rs) | (ex_writeReg == id_rt));
  assign adv     = ~memwait;

  always_comb begin
    pc_en_w      = 1'b0;
    ifid_en_w    = 1'b0;
    idex_en_w    = 1'b0;
    exmem_en_w   = 1'b0;
    memwb_en_w   = 1'b0;
    ifid_flush_w = 1'b0;
    idex_flush_w = 1'b0;
    halt_w       = 1'b0;
    case (state_q)
      HALTED: begin
        halt_w = 1'b1;
      end
      DRAIN: begin
        // Nothing younger than the halt may enter: fetch stays shut, ID gets bubbles.
        ifid_flush_w = 1'b1;
        if (!memwait) begin
          ifid_en_w  = 1'b1;
          idex_en_w  = 1'b1;
          exmem_en_w = 1'b1;
          memwb_en_w = 1'b1;
        end
      end
      default: begin
        if (memwait) begin
          pc_en_w = 1'b0;
        end else if (branch_taken) begin
          pc_en_w      = 1'b1;
          ifid_en_w    = 1'b1;
          idex_en_w    = 1'b1;
          exmem_en_w   = 1'b1;
          memwb_en_w   = 1'b1;
          ifid_flush_w = 1'b1;
          idex_flush_w = 1'b1;
        end else if (lduse || !ihit) begin
          idex_en_w    = 1'b1;
          exmem_en_w   = 1'b1;
          memwb_en_w   = 1'b1;
          idex_flush_w = 1'b1;
        end else begin
          pc_en_w    = 1'b1;
          ifid_en_w  = 1'b1;
          idex_en_w  = 1'b1;
          exmem_en_w = 1'b1;
          memwb_en_w = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (id_halt && ihit && adv && !branch_taken && !lduse) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (adv) begin
          drain_cnt_d = drain_cnt_q + C_DRAIN_ONE;
          if (drain_cnt_q == C_DRAIN_LAST) begin
            state_d = HALTED;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign stall_inc = (state_q != HALTED) & ~pc_en_w;
  assign flush_inc = (state_q == RUN) & ~memwait & branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  // Reset forces every control output low, independent of the decoded state.
  assign pc_en      = pc_en_w      & nRST;
  assign ifid_en    = ifid_en_w    & nRST;
  assign idex_en    = idex_en_w    & nRST;
  assign exmem_en   = exmem_en_w   & nRST;
  assign memwb_en   = memwb_en_w   & nRST;
  assign ifid_flush = ifid_flush_w & nRST;
  assign idex_flush = idex_flush_w & nRST;
  assign halt       = halt_w       & nRST;

endmodule

`default_nettype wire
